// File: rtl/frequency_analyzer_pkg.sv
// Shared definitions for the frequency analyzer register slave and its results reader.
package frequency_analyzer_pkg;

   // Reader FSM state encoding
   typedef enum logic [2:0] {
      StIdle,
      StAddr,
      StData,
      StPush,
      StDone
   } state_e;

   localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

   // Result index of each register word, pixel-major
   localparam logic [2:0] PIXEL0_F0 = 3'd0;
   localparam logic [2:0] PIXEL0_F1 = 3'd1;
   localparam logic [2:0] PIXEL1_F0 = 3'd2;
   localparam logic [2:0] PIXEL1_F1 = 3'd3;
   localparam logic [2:0] PIXEL2_F0 = 3'd4;
   localparam logic [2:0] PIXEL2_F1 = 3'd5;

   // Register count shared with the analyzer manager
   localparam int unsigned DEFAULT_REGISTERS_NUMBER = 6;

endpackage

// File: rtl/irq_edge_detector.sv
// Rising-edge pulse generator for the analyzer irq line.
// Define IRQ_SYNC_EN to insert a 2-flop synchronizer ahead of the edge detector.
module irq_edge_detector (
   input  logic clk_i,
   input  logic rst_i,
   input  logic irq_i,
   output logic edge_o
);

   logic irq_s;
   logic prev_q;

`ifdef IRQ_SYNC_EN
   logic sync1_q;
   logic sync2_q;

   // Two-flop synchronizer for an irq launched from a foreign clock
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= irq_i;
         sync2_q <= sync1_q;
      end
   end

   assign irq_s = sync2_q;
`else
   assign irq_s = irq_i;
`endif

   // Remember the previous level so only a low-to-high transition fires
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         prev_q <= 1'b0;
      end else begin
         prev_q <= irq_s;
      end
   end

   assign edge_o = irq_s & ~prev_q;

endmodule

// File: rtl/frequency_results_reader.sv
// AXI4-Lite read master: on each irq rising edge, reads registers 1..REGISTERS_NUMBER
// from the analyzer slave and forwards each word on an indexed valid/ready stream.
// Optional IRQ_SYNC_EN synchronizes irq (see irq_edge_detector).
module frequency_results_reader
   import frequency_analyzer_pkg::*;
#(
   parameter int unsigned C_M00_AXI_DATA_WIDTH = 32,
   parameter int unsigned C_M00_AXI_ADDR_WIDTH = 10,
   parameter int unsigned BASE_ADDR            = 0,
   parameter int unsigned REGISTERS_NUMBER     = DEFAULT_REGISTERS_NUMBER
) (
   input  logic                            m00_axi_aclk,
   input  logic                            m00_axi_areset,
   input  logic                            irq,
   output logic [C_M00_AXI_ADDR_WIDTH-1:0] m00_axi_araddr,
   output logic [2:0]                      m00_axi_arprot,
   output logic                            m00_axi_arvalid,
   input  logic                            m00_axi_arready,
   input  logic [C_M00_AXI_DATA_WIDTH-1:0] m00_axi_rdata,
   input  logic [1:0]                      m00_axi_rresp,
   input  logic                            m00_axi_rvalid,
   output logic                            m00_axi_rready,
   output logic [C_M00_AXI_DATA_WIDTH-1:0] result_data,
   output logic [2:0]                      result_index,
   output logic                            result_valid,
   input  logic                            result_ready,
   output logic                            busy,
   output logic                            done,
   output logic                            error,
   output logic                            overrun
);

   localparam logic [2:0] LastIdx = 3'(REGISTERS_NUMBER - 1);

   state_e                          state_q, state_d;
   logic [2:0]                      cnt_q, cnt_d;
   logic                            pending_q, pending_d;
   logic                            error_q, error_d;
   logic                            overrun_q, overrun_d;
   logic [C_M00_AXI_DATA_WIDTH-1:0] data_q, data_d;
   logic [2:0]                      index_q, index_d;
   logic                            irq_edge;
   logic                            start;

   irq_edge_detector u_irq_edge (
      .clk_i  (m00_axi_aclk),
      .rst_i  (m00_axi_areset),
      .irq_i  (irq),
      .edge_o (irq_edge)
   );

   assign start = (state_q == StIdle) && (irq_edge || pending_q);

   // State register; reset drops any in-flight read immediately
   always_ff @(posedge m00_axi_aclk or posedge m00_axi_areset) begin
      if (m00_axi_areset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: one outstanding read, then hand the word to the consumer
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (irq_edge || pending_q) state_d = StAddr;
         StAddr:  if (m00_axi_arready) state_d = StData;
         StData:  if (m00_axi_rvalid) state_d = StPush;
         StPush:  if (result_ready) state_d = (cnt_q == LastIdx) ? StDone : StAddr;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Datapath next-state: counter, pending/overrun bookkeeping, captured word
   always_comb begin
      cnt_d     = cnt_q;
      pending_d = pending_q;
      error_d   = error_q;
      overrun_d = overrun_q;
      data_d    = data_q;
      index_d   = index_q;

      if (state_q == StIdle) begin
         // A start consumes the pending edge; a fresh edge in the same cycle re-arms it
         pending_d = pending_q & irq_edge;
      end else if (irq_edge) begin
         if (pending_q) begin
            overrun_d = 1'b1;
         end else begin
            pending_d = 1'b1;
         end
      end

      if (start) begin
         error_d = 1'b0;
      end else if (state_q == StData && m00_axi_rvalid) begin
         data_d  = m00_axi_rdata;
         index_d = cnt_q;
         error_d = error_q | (m00_axi_rresp != AXI_RESP_OKAY);
      end

      if (state_q == StPush && result_ready && cnt_q != LastIdx) begin
         cnt_d = cnt_q + 3'd1;
      end else if (state_q == StDone) begin
         cnt_d = 3'd0;
      end
   end

   // Datapath registers
   always_ff @(posedge m00_axi_aclk or posedge m00_axi_areset) begin
      if (m00_axi_areset) begin
         cnt_q     <= 3'd0;
         pending_q <= 1'b0;
         error_q   <= 1'b0;
         overrun_q <= 1'b0;
         data_q    <= '0;
         index_q   <= 3'd0;
      end else begin
         cnt_q     <= cnt_d;
         pending_q <= pending_d;
         error_q   <= error_d;
         overrun_q <= overrun_d;
         data_q    <= data_d;
         index_q   <= index_d;
      end
   end

   // Outputs decoded from state; address is held stable for the whole ADDR phase
   always_comb begin
      m00_axi_arvalid = 1'b0;
      m00_axi_rready  = 1'b0;
      m00_axi_araddr  = '0;
      result_valid    = 1'b0;
      done            = 1'b0;
      busy            = 1'b0;
      unique case (state_q)
         StAddr: begin
            m00_axi_arvalid = 1'b1;
            m00_axi_araddr  = C_M00_AXI_ADDR_WIDTH'(BASE_ADDR)
                            + C_M00_AXI_ADDR_WIDTH'({cnt_q + 3'd1, 2'b00});
            busy            = 1'b1;
         end
         StData: begin
            m00_axi_rready = 1'b1;
            busy           = 1'b1;
         end
         StPush: begin
            result_valid = 1'b1;
            busy         = 1'b1;
         end
         StDone:  done = 1'b1;
         default: ;
      endcase
   end

   assign m00_axi_arprot = 3'b000;
   assign result_data    = data_q;
   assign result_index   = index_q;
   assign error          = error_q;
   assign overrun        = overrun_q;

endmodule

// File: tb/tb_frequency_results_reader.sv
// Directed bench for frequency_results_reader with a zero-wait AXI4-Lite slave model.
module tb_frequency_results_reader;

`ifdef IRQ_SYNC_EN
   localparam int Lat = 3;
`else
   localparam int Lat = 1;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        irq = 1'b0;
   logic [9:0]  araddr;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready = 1'b1;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic [31:0] result_data;
   logic [2:0]  result_index;
   logic        result_valid;
   logic        result_ready = 1'b1;
   logic        busy, done, error, overrun;

   logic [9:0]  err_addr = 10'h3ff;

   int checks = 0;
   int errors = 0;

   logic [9:0]  ar_log[$];
   logic [2:0]  idx_log[$];
   logic [31:0] dat_log[$];
   logic        err_log[$];
   int          done_cnt = 0;

   frequency_results_reader dut (
      .m00_axi_aclk    (clk),
      .m00_axi_areset  (rst),
      .irq             (irq),
      .m00_axi_araddr  (araddr),
      .m00_axi_arprot  (arprot),
      .m00_axi_arvalid (arvalid),
      .m00_axi_arready (arready),
      .m00_axi_rdata   (rdata),
      .m00_axi_rresp   (rresp),
      .m00_axi_rvalid  (rvalid),
      .m00_axi_rready  (rready),
      .result_data     (result_data),
      .result_index    (result_index),
      .result_valid    (result_valid),
      .result_ready    (result_ready),
      .busy            (busy),
      .done            (done),
      .error           (error),
      .overrun         (overrun)
   );

   always #5 clk = ~clk;

   // Slave: register k returns 100*k; err_addr answers SLVERR
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         rvalid <= 1'b0;
         rdata  <= 32'd0;
         rresp  <= 2'b00;
      end else begin
         if (rvalid && rready) rvalid <= 1'b0;
         if (arvalid && arready) begin
            rvalid <= 1'b1;
            rdata  <= 32'(araddr >> 2) * 32'd100;
            rresp  <= (araddr == err_addr) ? 2'b10 : 2'b00;
         end
      end
   end

   // Transaction monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (arvalid && arready) ar_log.push_back(araddr);
      if (result_valid && result_ready) begin
         idx_log.push_back(result_index);
         dat_log.push_back(result_data);
         err_log.push_back(error);
      end
      if (done) done_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_irq();
      irq = 1'b1;
      tick();
      irq = 1'b0;
   endtask

   task automatic wait_done(input int target, input int budget);
      for (int i = 0; i < budget && done_cnt < target; i++) tick();
      check("done_count", done_cnt, target);
   endtask

   // Cycles from irq rise (just after an edge) to arvalid seen mid-cycle
   task automatic measure_latency(output int n);
      n = -1;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (arvalid) begin
            n = i;
            break;
         end
      end
      tick();
   endtask

   int base_ar, base_res, d0, lat, gap;
   logic        stable;
   logic [31:0] sd;
   logic [2:0]  si;

   initial begin
      // Reset state
      tick();
      tick();
      check("rst_arvalid", arvalid, 0);
      check("rst_araddr", araddr, 0);
      check("rst_busy", busy, 0);
      check("rst_rready", rready, 0);
      rst = 1'b0;
      tick();
      tick();
      check("idle_result_valid", result_valid, 0);
      check("idle_done", done, 0);
      check("idle_error_overrun", {error, overrun, arprot}, 0);

      // 1: plain burst
      base_ar = ar_log.size(); base_res = idx_log.size(); d0 = done_cnt;
      irq = 1'b1;
      measure_latency(lat);
      irq = 1'b0;
      check("t1_latency", lat, Lat);
      wait_done(d0 + 1, 100);
      check("t1_ar_count", ar_log.size() - base_ar, 6);
      check("t1_res_count", idx_log.size() - base_res, 6);
      for (int k = 0; k < 6 && base_res + k < idx_log.size() && base_ar + k < ar_log.size(); k++) begin
         check($sformatf("t1_araddr%0d", k), ar_log[base_ar + k], 4 * (k + 1));
         check($sformatf("t1_index%0d", k), idx_log[base_res + k], k);
         check($sformatf("t1_data%0d", k), dat_log[base_res + k], 100 * (k + 1));
      end
      tick();
      check("t1_error", error, 0);
      check("t1_busy_after", busy, 0);

      // 2: consumer stalls word 2 for 10 cycles
      base_ar = ar_log.size(); d0 = done_cnt;
      result_ready = 1'b0;
      pulse_irq();
      for (int w = 0; w < 6; w++) begin
         for (int i = 0; i < 20 && !result_valid; i++) tick();
         check($sformatf("t2_index%0d", w), result_index, w);
         if (w == 2) begin
            sd = result_data; si = result_index; stable = 1'b1;
            repeat (10) begin
               tick();
               if (!result_valid || result_data !== sd || result_index !== si || arvalid)
                  stable = 1'b0;
            end
            check("t2_stall_stable", stable, 1);
            check("t2_stall_data", sd, 300);
         end
         result_ready = 1'b1;
         tick();
         result_ready = 1'b0;
      end
      result_ready = 1'b1;
      wait_done(d0 + 1, 100);
      check("t2_ar_count", ar_log.size() - base_ar, 6);

      // 3: slave error on register 3 (index 2)
      base_res = idx_log.size(); d0 = done_cnt;
      err_addr = 10'h00c;
      pulse_irq();
      wait_done(d0 + 1, 100);
      check("t3_res_count", idx_log.size() - base_res, 6);
      if (idx_log.size() - base_res >= 6) begin
         check("t3_err_at1", err_log[base_res + 1], 0);
         check("t3_err_at2", err_log[base_res + 2], 1);
         check("t3_err_at5", err_log[base_res + 5], 1);
      end
      tick();
      check("t3_err_sticky", error, 1);
      err_addr = 10'h3ff;
      d0 = done_cnt;
      pulse_irq();
      repeat (3) tick();
      check("t3_err_cleared", error, 0);
      wait_done(d0 + 1, 100);

      // 4: two extra irq edges mid-burst -> one pending, one overrun
      base_res = idx_log.size(); d0 = done_cnt;
      pulse_irq();
      repeat (3) tick();
      pulse_irq();
      tick();
      pulse_irq();
      wait_done(d0 + 1, 100);
      // done cycle, then IDLE restart cycle, then ADDR
      gap = -1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (arvalid) begin
            gap = i;
            break;
         end
      end
      tick();
      check("t4_restart_gap", gap, 1);
      wait_done(d0 + 2, 100);
      repeat (20) tick();
      check("t4_res_count", idx_log.size() - base_res, 12);
      check("t4_done_total", done_cnt - d0, 2);
      check("t4_overrun", overrun, 1);

      // 5: async reset during DATA of word 4
      pulse_irq();
      for (int i = 0; i < 60 && !(arvalid && araddr == 10'h014); i++) tick();
      check("t5_addr4", araddr, 10'h014);
      tick();
      check("t5_in_data", rready, 1);
      rst = 1'b1;
      #1;
      check("t5_rst_outs", {arvalid, rready, busy, result_valid, done, error, overrun}, 0);
      check("t5_rst_araddr", araddr, 0);
      check("t5_rst_result", {result_data, 3'(result_index)} == 0, 1);
      #2 rst = 1'b0;
      base_ar = ar_log.size(); d0 = done_cnt;
      repeat (20) tick();
      check("t5_quiet_ar", ar_log.size() - base_ar, 0);
      check("t5_quiet_busy", busy, 0);
      check("t5_quiet_done", done_cnt - d0, 0);

      // 6: irq held high 50 cycles -> single burst
      base_ar = ar_log.size(); base_res = idx_log.size(); d0 = done_cnt;
      irq = 1'b1;
      measure_latency(lat);
      check("t6_latency", lat, Lat);
      repeat (50) tick();
      irq = 1'b0;
      repeat (20) tick();
      check("t6_ar_count", ar_log.size() - base_ar, 6);
      check("t6_res_count", idx_log.size() - base_res, 6);
      check("t6_done_total", done_cnt - d0, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
